// File: rtl/mux_scan_n_pkg.sv
// mux_scan_n shared types: FSM state encoding and mode constants.
package mux_scan_n_pkg;

   typedef enum logic [1:0] {
      S_MANUAL = 2'd0,
      S_SCAN   = 2'd1,
      S_HOLD   = 2'd2
   } state_e;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_dwell_ctr.sv
// Dwell counter with wrap-around channel index.
module scan_dwell_ctr #(
   parameter int CHANNELS = 9,
   parameter int DWELL    = 16,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en,
   input  logic             clr,
   input  logic             ld,
   input  logic [SEL_W-1:0] ld_val,
   output logic [SEL_W-1:0] ch,
   output logic [SEL_W-1:0] ch_nxt,
   output logic             tc
);

   localparam int CW = $clog2(DWELL + 1);
   localparam logic [CW-1:0]    DW_LAST = CW'(DWELL - 1);
   localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

   logic [CW-1:0] dwell_q;
   logic [CW-1:0] dwell_d;

   assign tc = (dwell_q == DW_LAST);

   always_comb begin
      ch_nxt  = ch;
      dwell_d = dwell_q;
      if (ld) ch_nxt = ld_val;
      if (clr) begin
         dwell_d = '0;
      end else if (en) begin
         if (tc) begin
            dwell_d = '0;
            ch_nxt  = (ch == CH_LAST) ? '0 : ch + SEL_W'(1);
         end else begin
            dwell_d = dwell_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dwell_q <= '0;
         ch      <= '0;
      end else begin
         dwell_q <= dwell_d;
         ch      <= ch_nxt;
      end
   end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel selector: manual select, round-robin scan, hold.
module mux_scan_n
   import mux_scan_n_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 9,
   parameter int SEL_W    = $clog2(CHANNELS),
   parameter int DWELL    = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      mode_i,
   input  logic                      hold_i,
   input  logic [SEL_W-1:0]          sel_i,
   input  logic [CHANNELS*WIDTH-1:0] in_i,
   output logic [WIDTH-1:0]          out_o,
   output logic [SEL_W-1:0]          ch_o,
   output logic                      valid_o,
   output logic                      sel_err_o
);

   localparam logic [SEL_W:0] N_CH = (SEL_W + 1)'(CHANNELS);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] ch_val [2**SEL_W];
   logic [WIDTH-1:0] out_q, out_d;
   logic [SEL_W-1:0] ch, ch_nxt;
   logic             sel_ok, sel_bad_q;
   logic             valid_q, valid_d;
   logic             en, clr, ld, tc;

   // Unused index slots read as zero so any SEL_W-wide index is legal
   always_comb begin
      for (int k = 0; k < 2**SEL_W; k++) ch_val[k] = '0;
      for (int k = 0; k < CHANNELS; k++) ch_val[k] = in_i[k*WIDTH +: WIDTH];
   end

   assign sel_ok = ({1'b0, sel_i} < N_CH);

   always_comb begin
      state_d = S_SCAN;
      en      = 1'b0;
      clr     = 1'b0;
      ld      = 1'b0;
      out_d   = out_q;
      valid_d = 1'b0;
      if (hold_i) state_d = S_HOLD;
      else if (mode_i == MODE_MANUAL) state_d = S_MANUAL;
      else state_d = S_SCAN;
      unique case (state_d)
         S_MANUAL: begin
            clr = 1'b1;
            ld  = sel_ok;
            if (sel_ok) begin
               out_d   = ch_val[sel_i];
               valid_d = (sel_i != ch);
            end
         end
         S_SCAN: begin
            en      = 1'b1;
            out_d   = ch_val[ch_nxt];
            valid_d = tc;
         end
         default: ;
      endcase
   end

   scan_dwell_ctr #(
      .CHANNELS(CHANNELS),
      .DWELL   (DWELL),
      .SEL_W   (SEL_W)
   ) u_ctr (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en    (en),
      .clr   (clr),
      .ld    (ld),
      .ld_val(sel_i),
      .ch    (ch),
      .ch_nxt(ch_nxt),
      .tc    (tc)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_MANUAL;
         out_q     <= '0;
         valid_q   <= 1'b0;
         sel_bad_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         valid_q   <= valid_d;
         sel_bad_q <= !sel_ok;
      end
   end

   assign out_o     = out_q;
   assign ch_o      = ch;
   assign valid_o   = valid_q;
   assign sel_err_o = (state_q == S_MANUAL) && sel_bad_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: behavioural model plus directed and random stimulus.
module tb_mux_scan_n;

   localparam int W  = 8;
   localparam int C  = 9;
   localparam int D  = 4;
   localparam int SW = 4;
   localparam int W2 = 16;
   localparam int C2 = 2;
   localparam int D2 = 1;
   localparam int SW2 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n, mode, hold;
   logic [SW-1:0]   sel;
   logic [C*W-1:0]  in_a;
   logic [W-1:0]    out_a;
   logic [SW-1:0]   ch_a;
   logic            valid_a, err_a;

   logic            rst_b, mode_b, hold_b;
   logic [SW2-1:0]  sel_b;
   logic [C2*W2-1:0] in_b;
   logic [W2-1:0]   out_b;
   logic [SW2-1:0]  ch_b;
   logic            valid_b, err_b;

   int checks = 0;
   int failures = 0;
   bit cmp_on = 1'b0;

   mux_scan_n #(.WIDTH(W), .CHANNELS(C), .DWELL(D)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .hold_i(hold),
      .sel_i(sel), .in_i(in_a), .out_o(out_a), .ch_o(ch_a),
      .valid_o(valid_a), .sel_err_o(err_a)
   );

   mux_scan_n #(.WIDTH(W2), .CHANNELS(C2), .DWELL(D2)) dut_b (
      .clk_i(clk), .rst_ni(rst_b), .mode_i(mode_b), .hold_i(hold_b),
      .sel_i(sel_b), .in_i(in_b), .out_o(out_b), .ch_o(ch_b),
      .valid_o(valid_b), .sel_err_o(err_b)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int val_a(int k);
      return int'(in_a[k*W +: W]);
   endfunction

   task automatic set_base();
      for (int k = 0; k < C; k++) in_a[k*W +: W] = W'(8'h10 + k);
   endtask

   // Reference model: what the selector must show after each edge
   int m_out, m_ch, m_dw, m_prev;
   bit m_valid, m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_out = 0; m_ch = 0; m_dw = 0; m_valid = 0; m_err = 0;
      end else begin
         m_prev = m_ch;
         m_err = 0;
         if (hold) begin
         end else if (!mode) begin
            m_dw = 0;
            if (int'(sel) < C) begin
               m_ch = int'(sel);
               m_out = val_a(m_ch);
            end else begin
               m_err = 1;
            end
         end else begin
            if (m_dw == D - 1) begin
               m_dw = 0;
               m_ch = (m_ch + 1) % C;
            end else begin
               m_dw++;
            end
            m_out = val_a(m_ch);
         end
         m_valid = (m_ch != m_prev);
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("model_out", 32'(out_a), m_out);
         chk("model_ch", 32'(ch_a), m_ch);
         chk("model_valid", 32'(valid_a), 32'(m_valid));
         chk("model_sel_err", 32'(err_a), 32'(m_err));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pulses, wrap, prev, n, exp_b, idx;
      rst_n = 0; mode = 0; hold = 0; sel = '0;
      rst_b = 0; mode_b = 0; hold_b = 0; sel_b = '0; in_b = '0;
      set_base();
      repeat (3) @(negedge clk);
      cmp_on = 1'b1;
      chk("rst_out", 32'(out_a), 0);
      chk("rst_ch", 32'(ch_a), 0);
      chk("rst_valid", 32'(valid_a), 0);
      chk("rst_sel_err", 32'(err_a), 0);

      rst_n = 1; sel = 4'd3;
      @(posedge clk); #1;
      chk("man_out", 32'(out_a), 32'h13);
      chk("man_ch", 32'(ch_a), 3);
      chk("man_valid", 32'(valid_a), 1);
      @(posedge clk); #1;
      chk("man_same_valid", 32'(valid_a), 0);

      @(negedge clk); sel = 4'd12;
      @(posedge clk); #1;
      chk("oor_err", 32'(err_a), 1);
      chk("oor_out", 32'(out_a), 32'h13);
      chk("oor_ch", 32'(ch_a), 3);
      @(negedge clk); sel = 4'd8;
      @(posedge clk); #1;
      chk("sel8_out", 32'(out_a), 32'h18);
      chk("sel8_err", 32'(err_a), 0);
      chk("sel8_ch", 32'(ch_a), 8);

      @(negedge clk); sel = 4'd0;
      @(negedge clk); mode = 1;
      pulses = 0; wrap = 0; prev = int'(ch_a);
      for (int i = 0; i < C * D; i++) begin
         @(posedge clk); #1;
         if (valid_a) pulses++;
         if (prev == C - 1 && int'(ch_a) == 0) wrap = 1;
         prev = int'(ch_a);
      end
      chk("rot_pulses", 32'(pulses), C);
      chk("rot_wrap", 32'(wrap), 1);
      chk("rot_ch", 32'(ch_a), 0);

      repeat (2) @(posedge clk);
      @(negedge clk); hold = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_a[$urandom_range(0, C-1)*W +: W] = W'($urandom);
      end
      hold = 0;
      chk("hold_ch", 32'(ch_a), 0);
      @(posedge clk); #1;
      chk("rel1_ch", 32'(ch_a), 0);
      @(posedge clk); #1;
      chk("rel2_ch", 32'(ch_a), 1);
      chk("rel2_valid", 32'(valid_a), 1);

      @(negedge clk); set_base();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         hold = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         sel = SW'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) begin
            idx = $urandom_range(0, C-1);
            in_a[idx*W +: W] = W'($urandom);
         end
      end

      @(negedge clk); hold = 0; mode = 0; sel = 4'd4; set_base();
      @(negedge clk); mode = 1;
      n = 0;
      while (ch_a != 4'd5 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wait_ch5", 32'(ch_a), 5);
      #2 rst_n = 0;
      #1;
      chk("arst_out", 32'(out_a), 0);
      chk("arst_ch", 32'(ch_a), 0);
      chk("arst_valid", 32'(valid_a), 0);
      chk("arst_sel_err", 32'(err_a), 0);
      @(negedge clk); rst_n = 1; mode = 0; sel = 4'd2;
      @(posedge clk); #1;
      chk("restart_ch", 32'(ch_a), 2);
      chk("restart_out", 32'(out_a), 32'h12);

      chk("b_rst_ch", 32'(ch_b), 0);
      @(negedge clk); rst_b = 1; mode_b = 1; in_b = $urandom;
      exp_b = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         exp_b = 1 - exp_b;
         chk("b_ch", 32'(ch_b), exp_b);
         chk("b_valid", 32'(valid_b), 1);
         chk("b_out", 32'(out_b), 32'(in_b[exp_b*W2 +: W2]));
         @(negedge clk); in_b = $urandom;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
